// File: rtl/fpmul_driver.sv
// fpmul_driver: LFSR operand generator and in-order result logger for an FP multiplier.
// Define FPMUL_DRV_STALL_EN to add pseudo-random result backpressure.
module fpmul_driver #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] num_txn,
  input  logic [31:0] seed,
  output logic [31:0] op_a,
  output logic [31:0] op_b,
  output logic        op_valid,
  input  logic        op_ready,
  input  logic [31:0] res_data,
  input  logic        res_valid,
  output logic        res_ready,
  output logic        log_valid,
  output logic [31:0] log_a,
  output logic [31:0] log_b,
  output logic [31:0] log_z,
  output logic [15:0] issued_cnt,
  output logic [15:0] done_cnt,
  output logic        busy,
  output logic        done
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [31:0] POLY = 32'h8020_0003;
  localparam logic [31:0] BMIX = 32'hA5A5_A5A5;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t      r_state;
  logic [31:0] r_lfsr_a, r_lfsr_b;
  logic [15:0] r_num, r_iss, r_don;
  logic [AW:0] r_wp, r_rp;
  logic [31:0] r_fa [DEPTH];
  logic [31:0] r_fb [DEPTH];
  logic        r_logv;
  logic [31:0] r_la, r_lb, r_lz;

  logic        w_run, w_act, w_full, w_empty;
  logic        w_push, w_pop, w_stall;
  logic [31:0] w_seed_a, w_seed_b;

  function automatic logic [31:0] step(input logic [31:0] s);
    return {1'b0, s[31:1]} ^ (s[0] ? POLY : 32'h0);
  endfunction

  assign w_run   = (r_state == RUN);
  assign w_act   = (r_state == RUN) || (r_state == DRAIN);
  assign w_empty = (r_wp == r_rp);
  assign w_full  = (r_wp[AW] != r_rp[AW]) &&
                   (r_wp[AW-1:0] == r_rp[AW-1:0]);

  assign w_seed_a = (seed == 32'h0) ? 32'h1 : seed;
  assign w_seed_b = ((seed ^ BMIX) == 32'h0) ? 32'h1 : (seed ^ BMIX);

`ifdef FPMUL_DRV_STALL_EN
  logic [7:0] r_stl;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stl <= 8'h01;
    end else if (w_act) begin
      r_stl <= {r_stl[6:0], r_stl[7] ^ r_stl[5] ^ r_stl[4] ^ r_stl[3]};
    end
  end
  assign w_stall = r_stl[0];
`else
  assign w_stall = 1'b0;
`endif

  // full already blocks op_valid, so a same-cycle pop never frees a slot early
  assign op_valid  = w_run && (r_iss < r_num) && !w_full;
  assign res_ready = w_act && !w_empty && !w_stall;
  assign w_push    = op_valid && op_ready;
  assign w_pop     = res_ready && res_valid;

  assign op_a       = w_run ? r_lfsr_a : 32'h0;
  assign op_b       = w_run ? r_lfsr_b : 32'h0;
  assign log_valid  = r_logv;
  assign log_a      = r_la;
  assign log_b      = r_lb;
  assign log_z      = r_lz;
  assign issued_cnt = r_iss;
  assign done_cnt   = r_don;
  assign busy       = w_act;
  assign done       = (r_state == DONE);

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fa[r_wp[AW-1:0]] <= r_lfsr_a;
      r_fb[r_wp[AW-1:0]] <= r_lfsr_b;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_lfsr_a <= 32'h1;
      r_lfsr_b <= 32'h1;
      r_num    <= '0;
      r_iss    <= '0;
      r_don    <= '0;
      r_wp     <= '0;
      r_rp     <= '0;
      r_logv   <= 1'b0;
      r_la     <= '0;
      r_lb     <= '0;
      r_lz     <= '0;
    end else begin
      r_logv <= w_pop;
      if (w_pop) begin
        r_la  <= r_fa[r_rp[AW-1:0]];
        r_lb  <= r_fb[r_rp[AW-1:0]];
        r_lz  <= res_data;
        r_don <= r_don + 16'd1;
        r_rp  <= r_rp + 1'b1;
      end
      if (w_push) begin
        r_lfsr_a <= step(r_lfsr_a);
        r_lfsr_b <= step(r_lfsr_b);
        r_iss    <= r_iss + 16'd1;
        r_wp     <= r_wp + 1'b1;
      end
      unique case (r_state)
        IDLE, DONE: begin
          if (start) begin
            r_num    <= num_txn;
            r_iss    <= '0;
            r_don    <= '0;
            r_wp     <= '0;
            r_rp     <= '0;
            r_lfsr_a <= w_seed_a;
            r_lfsr_b <= w_seed_b;
            r_state  <= (num_txn != 16'd0) ? RUN : DONE;
          end
        end
        RUN: begin
          if (w_push && (r_iss + 16'd1 == r_num))
            r_state <= DRAIN;
        end
        DRAIN: begin
          if (w_pop && (r_don + 16'd1 == r_num))
            r_state <= DONE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fpmul_driver.sv
// tb_fpmul_driver: queue-based reference model with per-cycle compare
// plus directed scenarios with literal expectations.
module tb_fpmul_driver;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] num_txn = '0;
  logic [31:0] seed = '0;
  logic [31:0] op_a, op_b;
  logic        op_valid;
  logic        op_ready = 1'b0;
  logic [31:0] res_data = '0;
  logic        res_valid = 1'b0;
  logic        res_ready;
  logic        log_valid;
  logic [31:0] log_a, log_b, log_z;
  logic [15:0] issued_cnt, done_cnt;
  logic        busy, done;

  always #5 clk = ~clk;

  fpmul_driver #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .num_txn(num_txn), .seed(seed),
    .op_a(op_a), .op_b(op_b),
    .op_valid(op_valid), .op_ready(op_ready),
    .res_data(res_data), .res_valid(res_valid),
    .res_ready(res_ready), .log_valid(log_valid),
    .log_a(log_a), .log_b(log_b), .log_z(log_z),
    .issued_cnt(issued_cnt), .done_cnt(done_cnt),
    .busy(busy), .done(done)
  );

  int n_chk = 0;
  int n_pass = 0;
  int n_logs = 0;
  logic [31:0] la_seen[$];

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
  endtask

  // reference model: phase 0 idle, 1 run, 2 drain, 3 done
  int          ph, m_num, m_iss, m_don;
  logic [31:0] m_a, m_b, m_la, m_lb, m_lz;
  bit          m_logv;
  logic [31:0] qa[$];
  logic [31:0] qb[$];

  function automatic logic [31:0] lstep(input logic [31:0] s);
    logic [31:0] r;
    r = s >> 1;
    if (s[0]) r = r ^ 32'h8020_0003;
    return r;
  endfunction

  task automatic m_reset();
    ph = 0; m_num = 0; m_iss = 0; m_don = 0;
    m_a = 32'h1; m_b = 32'h1;
    m_la = 0; m_lb = 0; m_lz = 0; m_logv = 0;
    qa.delete(); qb.delete();
  endtask

  function automatic bit m_opv();
    return (ph == 1) && (m_iss < m_num) && (qa.size() < DEPTH);
  endfunction

  function automatic bit m_rr();
    return (ph == 1 || ph == 2) && (qa.size() > 0);
  endfunction

  always @(negedge rst_n) m_reset();

  always @(posedge clk) begin
    bit pu, po;
    int ph0;
    if (rst_n) begin
      pu = m_opv() && op_ready;
      po = m_rr() && res_valid;
      ph0 = ph;
      m_logv = po;
      if (po) begin
        m_la = qa.pop_front();
        m_lb = qb.pop_front();
        m_lz = res_data;
        m_don++;
      end
      if (pu) begin
        qa.push_back(m_a);
        qb.push_back(m_b);
        m_a = lstep(m_a);
        m_b = lstep(m_b);
        m_iss++;
      end
      if ((ph0 == 0 || ph0 == 3) && start) begin
        m_num = int'(num_txn);
        m_iss = 0; m_don = 0;
        qa.delete(); qb.delete();
        m_a = (seed == 0) ? 32'h1 : seed;
        m_b = ((seed ^ 32'hA5A5A5A5) == 0) ? 32'h1 : (seed ^ 32'hA5A5A5A5);
        ph = (num_txn != 0) ? 1 : 3;
      end else if (ph0 == 1 && m_iss == m_num) begin
        ph = 2;
      end else if (ph0 == 2 && m_don == m_num) begin
        ph = 3;
      end
    end
  end

  always @(negedge clk) begin
    chk("op_valid", op_valid, m_opv());
    if (m_opv()) begin
      chk("op_a", op_a, m_a);
      chk("op_b", op_b, m_b);
    end
    chk("res_ready", res_ready, m_rr());
    chk("log_valid", log_valid, m_logv);
    chk("log_a", log_a, m_la);
    chk("log_b", log_b, m_lb);
    chk("log_z", log_z, m_lz);
    chk("issued_cnt", issued_cnt, 32'(m_iss));
    chk("done_cnt", done_cnt, 32'(m_don));
    chk("busy", busy, (ph == 1 || ph == 2));
    chk("done", done, (ph == 3));
    if (log_valid) begin
      n_logs++;
      la_seen.push_back(log_a);
    end
  end

  task automatic go(logic [31:0] s, logic [15:0] n);
    @(negedge clk); #1;
    seed = s; num_txn = n; start = 1'b1;
    @(negedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(int lim);
    int k;
    k = 0;
    while (!done && k < lim) begin
      @(negedge clk); #1;
      k++;
    end
    chk("wait_done", done, 1);
  endtask

  initial begin
    m_reset();
    #3;
    chk("rst_op_valid", op_valid, 0);
    chk("rst_op_a", op_a, 0);
    chk("rst_busy", busy, 0);
    chk("rst_issued", issued_cnt, 0);
    @(negedge clk); #2;
    rst_n = 1'b1;

    // single transaction with known result
    op_ready = 1; res_valid = 1; res_data = 32'h12345678;
    go(32'h3F800000, 1);
    chk("t1_op_a", op_a, 32'h3F800000);
    chk("t1_op_b", op_b, 32'h9A25A5A5);
    wait_done(20);
    chk("t1_log_a", log_a, 32'h3F800000);
    chk("t1_log_b", log_b, 32'h9A25A5A5);
    chk("t1_log_z", log_z, 32'h12345678);
    chk("t1_issued", issued_cnt, 1);
    chk("t1_donecnt", done_cnt, 1);

    // operand stall; a start pulse mid-run must be ignored
    op_ready = 0;
    go(32'hC0DE0001, 3);
    for (int i = 0; i < 10; i++) begin
      start = (i == 4);
      seed = 32'h55555555;
      num_txn = 16'd9;
      chk("t2_op_valid", op_valid, 1);
      chk("t2_op_a", op_a, 32'hC0DE0001);
      chk("t2_op_b", op_b, 32'h657BA5A4);
      chk("t2_issued", issued_cnt, 0);
      @(negedge clk); #1;
    end
    start = 0;
    op_ready = 1;
    wait_done(40);
    chk("t2_issued_end", issued_cnt, 3);

    // fill FIFO with results held off, then drain
    res_valid = 0; res_data = 32'hCAFE0000;
    go(32'h000000FF, 8);
    repeat (10) begin @(negedge clk); #1; end
    chk("t3_issued4", issued_cnt, 4);
    chk("t3_opv_low", op_valid, 0);
    n_logs = 0;
    la_seen.delete();
    res_valid = 1;
    wait_done(60);
    chk("t3_nlogs", n_logs, 8);
    chk("t3_first", la_seen.size() > 0 ? la_seen[0] : 32'hX, 32'h000000FF);
    chk("t3_second", la_seen.size() > 1 ? la_seen[1] : 32'hX, 32'h8020007C);

    // zero seed substitution
    go(32'h0, 1);
    chk("t4_op_a", op_a, 32'h1);
    chk("t4_op_b", op_b, 32'hA5A5A5A5);
    wait_done(20);
    go(32'hA5A5A5A5, 1);
    chk("t4b_op_b", op_b, 32'h1);
    wait_done(20);

    // empty run
    go(32'h1234, 0);
    chk("t5_done", done, 1);
    chk("t5_opv", op_valid, 0);

    // reset with three in flight
    res_valid = 0;
    go(32'h0BADF00D, 6);
    for (int k = 0; k < 20 && issued_cnt < 3; k++) begin
      @(negedge clk); #1;
    end
    op_ready = 0;
    chk("t6_inflight", issued_cnt, 3);
    #2;
    rst_n = 0;
    #1;
    chk("t6_opv", op_valid, 0);
    chk("t6_rr", res_ready, 0);
    chk("t6_issued", issued_cnt, 0);
    chk("t6_busy", busy, 0);
    chk("t6_op_a", op_a, 0);
    @(negedge clk); #2;
    rst_n = 1;
    op_ready = 1; res_valid = 1; res_data = 32'h0F0F0F0F;
    go(32'h3F800000, 2);
    wait_done(30);
    chk("t6_last_a", log_a, 32'h1FC00000);

    // randomized handshakes, overlapping push and pop
    go(32'hDEADBEEF, 12);
    for (int k = 0; k < 300 && !done; k++) begin
      op_ready = 1'($urandom_range(0, 1));
      res_valid = 1'($urandom_range(0, 1));
      res_data = $urandom;
      @(negedge clk); #1;
    end
    chk("t7_done", done, 1);
    chk("t7_cnt", done_cnt, 12);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/fpmul_driver.md
FPMUL_DRIVER -- requirements
Module: fpmul_driver

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, ports clk and rst_n.
REQ-002 Parameter DEPTH SHALL default to 4 and set the in-flight operand FIFO depth, power of two, 2..16.
REQ-003 clk  in  1  rising-edge clock.
REQ-004 rst_n  in  1  asynchronous active-low reset.
REQ-005 start  in  1  single-cycle request to begin a run.
REQ-006 num_txn  in  16  transactions per run, sampled on the accepted start.
REQ-007 seed  in  32  operand LFSR seed, sampled on the accepted start.
REQ-008 op_a, op_b  out  32 each  IEEE-754 single operand bit patterns to the multiplier.
REQ-009 op_valid  out  1 / op_ready  in  1  operand handshake; the transfer occurs on an edge where both are high.
REQ-010 res_data  in  32 / res_valid  in  1 / res_ready  out  1  result handshake; the transfer occurs on an edge where both are high.
REQ-011 log_valid  out  1 / log_a, log_b, log_z  out  32 each  matched operand/result record.
REQ-012 issued_cnt, done_cnt  out  16 each  operands issued / results accepted in the current run.
REQ-013 busy, done  out  1 each  run status.

Function
REQ-014 The FSM SHALL have states IDLE, RUN, DRAIN and DONE.
REQ-015 In IDLE or DONE, start with num_txn>0 SHALL clear the counters, load the LFSRs and enter RUN; start with num_txn=0 SHALL enter DONE.
REQ-016 start SHALL be ignored in RUN and DRAIN.
REQ-017 LFSR_A SHALL load seed and LFSR_B SHALL load seed^0xA5A5A5A5; either loaded value that equals 0 SHALL be replaced by 0x00000001.
REQ-018 Both LFSRs SHALL be 32-bit Galois with polynomial x^32+x^22+x^2+x+1 (mask 0x80200003) and SHALL each advance one step per accepted operand.
REQ-019 op_a and op_b SHALL equal the current LFSR_A and LFSR_B states.
REQ-020 op_valid SHALL be high in RUN while issued_cnt<num_txn and the FIFO is not full.
REQ-021 op_a and op_b SHALL stay stable while op_valid is high and op_ready is low.
REQ-022 Each accepted operand pair SHALL be pushed into the FIFO and SHALL increment issued_cnt.
REQ-023 A push SHALL be blocked when the FIFO is full, even if a pop occurs in the same cycle.
REQ-024 RUN SHALL go to DRAIN on the edge where issued_cnt reaches num_txn.
REQ-025 res_ready SHALL be high whenever the FIFO is non-empty (subject to REQ-035), in RUN or DRAIN; otherwise it SHALL be low.
REQ-026 Each accepted result SHALL pop the FIFO head in order and SHALL increment done_cnt.
REQ-027 On the cycle after each accepted result, log_valid SHALL pulse high for one cycle, with log_a/log_b set to the popped operands and log_z set to res_data.
REQ-028 log_a/log_b/log_z SHALL hold their values between pulses.
REQ-029 A push and a pop in the same cycle SHALL both occur when the FIFO is not full.
REQ-030 DRAIN SHALL go to DONE on the edge where done_cnt reaches num_txn.
REQ-031 busy SHALL be high in RUN and DRAIN.
REQ-032 done SHALL be high in DONE only.
REQ-033 The FIFO pointers SHALL wrap modulo DEPTH, with full and empty distinguished by an extra pointer bit.

Reset
REQ-034 While rst_n is low, regardless of clk: state SHALL be IDLE, FIFO empty, LFSRs 0x00000001, and all outputs, counters and log registers 0. A reset asserted mid-run SHALL discard all in-flight operands.

Configuration
REQ-035 With FPMUL_DRV_STALL_EN defined, an 8-bit Fibonacci LFSR (taps 8,6,5,4, reset value 0x01) SHALL advance every cycle in RUN/DRAIN, and res_ready SHALL be forced low whenever its bit 0 is 1.
REQ-036 Without FPMUL_DRV_STALL_EN, the stall LFSR SHALL not exist and res_ready SHALL follow REQ-025 only.

Verification
REQ-037 seed=0x3F800000, num_txn=1, and the bench returns 0x12345678 -> op_a=0x3F800000, op_b=0x9A25A5A5, then log_a/log_b/log_z=0x3F800000/0x9A25A5A5/0x12345678, issued_cnt=done_cnt=1, done=1.
REQ-038 op_ready held low for 10 cycles after start -> op_valid stays high, op_a/op_b are unchanged, issued_cnt=0.
REQ-039 DEPTH=4, num_txn=8, res_valid low -> exactly 4 issued, then op_valid=0; releasing res_valid -> 8 logs in issue order, then done=1.
REQ-040 seed=0 -> first op_a=0x00000001.
REQ-041 start with num_txn=0 -> DONE on the next edge, op_valid never high.
REQ-042 rst_n pulsed low mid-run with 3 in flight -> all outputs 0 immediately, and a subsequent run starts from an empty FIFO.
